pim_conv_seq: RTL and testbench



---
 rtl/pim_conv_pkg.sv | 21 ++
 rtl/pim_shift_acc.sv | 44 ++++
 rtl/pim_conv_seq.sv | 141 ++++++++++++++
 tb/tb_pim_conv_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_conv_pkg.sv
// Shared state type and width helpers for the bit-serial PIM dot-product sequencer.
package pim_conv_pkg;

   typedef enum logic [2:0] {IDLE, FEED, DRAIN, OUT, DONE} state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) r++;
      return r;
   endfunction

   // Accumulator width covering sum over s of (2^adc_p-1)*(2^input_p-1) << s*ws_p.
   function automatic int unsigned acc_width(input int unsigned adc_p,
                                             input int unsigned input_p,
                                             input int unsigned w_slices,
                                             input int unsigned ws_p);
      return adc_p + input_p + (w_slices - 1) * ws_p + clog2(w_slices);
   endfunction

endpackage

// File: rtl/pim_shift_acc.sv
// Shift-and-add accumulator for one crossbar column: weights each slice result by
// input bit position and slice significance; exposes the saturated value.
module pim_shift_acc #(
   parameter int unsigned W_SLICES = 2,
   parameter int unsigned ADC_P    = 4,
   parameter int unsigned WS_P     = 4,
   parameter int unsigned BW       = 4,
   parameter int unsigned ACC_W    = 17,
   parameter int unsigned OUT_P    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [W_SLICES*ADC_P-1:0] i_res,
   input  logic [BW-1:0]             i_bit,
   input  logic                      i_clr,
   input  logic                      i_en,
   output logic [OUT_P-1:0]          o_sat
);

   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_sum;
   logic             w_over;

   always_comb begin
      w_sum = '0;
      for (int s = 0; s < int'(W_SLICES); s++) begin
         w_sum = w_sum + (ACC_W'(i_res[s*ADC_P +: ADC_P]) << (int'(i_bit) + s * int'(WS_P)));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc <= '0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= r_acc + w_sum;
      end
   end

   assign w_over = (r_acc >> OUT_P) != '0;
   assign o_sat  = w_over ? '1 : OUT_P'(r_acc);

endmodule

// File: rtl/pim_conv_seq.sv
// Bit-serial PIM dot-product sequencer: streams a latched feature vector LSB-first into
// external weight-slice crossbars over a run of column addresses and emits one result each.
module pim_conv_seq
   import pim_conv_pkg::*;
#(
   parameter int unsigned INPUT_SIZE = 32,
   parameter int unsigned INPUT_P    = 8,
   parameter int unsigned W_SLICES   = 2,
   parameter int unsigned WS_P       = 4,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned ADC_P      = 4,
   parameter int unsigned OUT_P      = 16,
   localparam int unsigned AW        = clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_start,
   input  logic [INPUT_SIZE*INPUT_P-1:0] i_in_feature,
   input  logic [AW-1:0]                 i_addr_base,
   input  logic [AW:0]                   i_addr_cnt,
   output logic                          o_busy,
   output logic [INPUT_SIZE-1:0]         o_xbar_in,
   output logic [AW-1:0]                 o_xbar_addr,
   output logic                          o_xbar_en,
   input  logic [W_SLICES*ADC_P-1:0]     i_xbar_res,
   output logic [OUT_P-1:0]              o_out_data,
   output logic [AW-1:0]                 o_out_addr,
   output logic                          o_out_valid,
   input  logic                          i_out_ready,
   output logic                          o_done
);

   localparam int unsigned CW    = AW + 1;
   localparam int unsigned BW    = clog2(INPUT_P + 1);
   localparam int unsigned ACC_W = acc_width(ADC_P, INPUT_P, W_SLICES, WS_P);

   state_e                        r_state, w_state_nxt;
   logic [INPUT_SIZE*INPUT_P-1:0] r_feat;
   logic [AW-1:0]                 r_cur_addr;
   logic [CW-1:0]                 r_remaining;
   logic [BW-1:0]                 r_bit, r_bit_d;
   logic                          r_en_d, r_zero_done;
   logic                          w_load, w_next_addr, w_clr;
   logic [INPUT_SIZE-1:0]         w_plane;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_next_addr = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_start && (i_addr_cnt != '0)) begin
               w_load      = 1'b1;
               w_state_nxt = FEED;
            end
         end
         FEED:  if (r_bit == BW'(INPUT_P - 1)) w_state_nxt = DRAIN;
         DRAIN: w_state_nxt = OUT;
         OUT: begin
            if (i_out_ready) begin
               if (r_remaining > CW'(1)) begin
                  w_next_addr = 1'b1;
                  w_state_nxt = FEED;
               end else begin
                  w_state_nxt = DONE;
               end
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_clr = w_load | w_next_addr;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_feat      <= '0;
         r_cur_addr  <= '0;
         r_remaining <= '0;
         r_bit       <= '0;
         r_bit_d     <= '0;
         r_en_d      <= 1'b0;
         r_zero_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_zero_done <= (r_state == IDLE) && i_start && (i_addr_cnt == '0);
         // ADC result for a bit plane arrives one cycle after its strobe.
         r_en_d      <= (r_state == FEED);
         r_bit_d     <= r_bit;
         if (w_load) begin
            r_feat      <= i_in_feature;
            r_cur_addr  <= i_addr_base;
            r_remaining <= i_addr_cnt;
            r_bit       <= '0;
         end else if (w_next_addr) begin
            r_remaining <= r_remaining - CW'(1);
            r_cur_addr  <= (r_cur_addr == AW'(DEPTH - 1)) ? '0 : r_cur_addr + AW'(1);
            r_bit       <= '0;
         end else if (r_state == FEED) begin
            r_bit <= r_bit + BW'(1);
         end
      end
   end

   always_comb begin
      w_plane = '0;
      if (r_state == FEED) begin
         for (int i = 0; i < int'(INPUT_SIZE); i++) begin
            w_plane[i] = r_feat[i*int'(INPUT_P) + int'(r_bit)];
         end
      end
   end

   pim_shift_acc #(
      .W_SLICES (W_SLICES),
      .ADC_P    (ADC_P),
      .WS_P     (WS_P),
      .BW       (BW),
      .ACC_W    (ACC_W),
      .OUT_P    (OUT_P)
   ) u_acc (
      .clk   (clk),
      .rst   (rst),
      .i_res (i_xbar_res),
      .i_bit (r_bit_d),
      .i_clr (w_clr),
      .i_en  (r_en_d),
      .o_sat (o_out_data)
   );

   assign o_busy      = (r_state != IDLE);
   assign o_xbar_en   = (r_state == FEED);
   assign o_xbar_in   = w_plane;
   assign o_xbar_addr = r_cur_addr;
   assign o_out_valid = (r_state == OUT);
   assign o_out_addr  = r_cur_addr;
   assign o_done      = (r_state == DONE) | r_zero_done;

endmodule

// File: tb/tb_pim_conv_seq.sv
// Randomized bench for pim_conv_seq: two instances (OUT_P 16 and 12) against a
// bit-plane dot-product reference model and a per-address expectation queue.
module tb_pim_conv_seq;

   localparam int IS  = 32;
   localparam int IP  = 8;
   localparam int WSL = 2;
   localparam int WSP = 4;
   localparam int DEP = 32;
   localparam int ADP = 4;
   localparam int AWT = 5;

   typedef struct {
      int     addr;
      longint d16;
      longint d12;
   } exp_t;

   logic                  clk, rst, start, ready;
   logic [IS*IP-1:0]      feat;
   logic [AWT-1:0]        base;
   logic [AWT:0]          cnt;

   logic                  busy_a, xen_a, valid_a, done_a;
   logic [IS-1:0]         xin_a;
   logic [AWT-1:0]        xaddr_a, addr_a;
   logic [WSL*ADP-1:0]    res_a;
   logic [15:0]           data_a;

   logic                  busy_b, xen_b, valid_b, done_b;
   logic [IS-1:0]         xin_b;
   logic [AWT-1:0]        xaddr_b, addr_b;
   logic [WSL*ADP-1:0]    res_b;
   logic [11:0]           data_b;

   int                    n_vec, n_bad, n_hs, mode;
   logic [IS-1:0]         wm [WSL][DEP];
   exp_t                  q [$];

   pim_conv_seq #(.OUT_P(16)) u_dut (
      .clk(clk), .rst(rst), .i_start(start), .i_in_feature(feat), .i_addr_base(base),
      .i_addr_cnt(cnt), .o_busy(busy_a), .o_xbar_in(xin_a), .o_xbar_addr(xaddr_a),
      .o_xbar_en(xen_a), .i_xbar_res(res_a), .o_out_data(data_a), .o_out_addr(addr_a),
      .o_out_valid(valid_a), .i_out_ready(ready), .o_done(done_a)
   );

   pim_conv_seq #(.OUT_P(12)) u_dut12 (
      .clk(clk), .rst(rst), .i_start(start), .i_in_feature(feat), .i_addr_base(base),
      .i_addr_cnt(cnt), .o_busy(busy_b), .o_xbar_in(xin_b), .o_xbar_addr(xaddr_b),
      .o_xbar_en(xen_b), .i_xbar_res(res_b), .o_out_data(data_b), .o_out_addr(addr_b),
      .o_out_valid(valid_b), .i_out_ready(ready), .o_done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Crossbar behaviour: 0 = constant 1, 1 = fixed 3/2 on any active plane,
   // 2 = saturating popcount of plane against random per-column weights.
   function automatic int xbar_fn(input logic [IS-1:0] plane, input int addr, input int s);
      int pc;
      if (mode == 0) return 1;
      if (mode == 1) return (plane != '0) ? ((s == 0) ? 3 : 2) : 0;
      pc = $countones(plane & wm[s][addr]);
      return (pc > 15) ? 15 : pc;
   endfunction

   function automatic logic [IS-1:0] plane_of(input logic [IS*IP-1:0] f, input int b);
      logic [IS-1:0] p;
      for (int i = 0; i < IS; i++) p[i] = f[i*IP + b];
      return p;
   endfunction

   function automatic longint model(input logic [IS*IP-1:0] f, input int addr, input int outp);
      longint acc;
      acc = 0;
      for (int b = 0; b < IP; b++)
         for (int s = 0; s < WSL; s++)
            acc += longint'(xbar_fn(plane_of(f, b), addr, s)) << (b + WSP * s);
      if (acc >= (64'sd1 <<< outp)) acc = (64'sd1 <<< outp) - 1;
      return acc;
   endfunction

   always @(posedge clk) begin
      for (int s = 0; s < WSL; s++) begin
         res_a[s*ADP +: ADP] <= xen_a ? 4'(xbar_fn(xin_a, int'(xaddr_a), s)) : 4'($urandom);
         res_b[s*ADP +: ADP] <= xen_b ? 4'(xbar_fn(xin_b, int'(xaddr_b), s)) : 4'($urandom);
      end
   end

   // Compare process: inputs settle at the falling edge, so sample just after it.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         if (valid_a || valid_b) begin
            if (q.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               check("out_valid", valid_a, 1);
               check("out_valid_op12", valid_b, 1);
               check("out_data", data_a, q[0].d16);
               check("out_data_op12", data_b, q[0].d12);
               check("out_addr", addr_a, q[0].addr);
               check("out_addr_op12", addr_b, q[0].addr);
               check("feed_while_out", xen_a, 0);
               if (ready) begin
                  q.delete(0);
                  n_hs++;
               end
            end
         end
         if (xen_a && q.size() > 0) check("xbar_addr", xaddr_a, q[0].addr);
         if (xen_b && q.size() > 0) check("xbar_addr_op12", xaddr_b, q[0].addr);
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, busy_a, 0);
      check({tag, "_xbar_en"}, xen_a, 0);
      check({tag, "_out_valid"}, valid_a, 0);
      check({tag, "_done"}, done_a, 0);
      check({tag, "_xbar_in"}, xin_a, 0);
      check({tag, "_xbar_addr"}, xaddr_a, 0);
      check({tag, "_out_data"}, data_a, 0);
      check({tag, "_out_addr"}, addr_a, 0);
   endtask

   task automatic rand_feat();
      for (int i = 0; i < IS; i++) feat[i*IP +: IP] = 8'($urandom);
   endtask

   // Called at a falling edge; stall>0 holds ready low that many cycles at the first
   // result (pulsing start meanwhile), stall<0 randomizes ready.
   task automatic run(input int b, input int c, input int stall, output int lat,
                      output int done_at, output int ndone, output int busy_seen,
                      output longint d16, output longint d12);
      exp_t e;
      int   st;
      bit   stalled;
      base = AWT'(b);
      cnt  = (AWT + 1)'(c);
      for (int j = 0; j < c; j++) begin
         e.addr = (b + j) % DEP;
         e.d16  = model(feat, e.addr, 16);
         e.d12  = model(feat, e.addr, 12);
         q.push_back(e);
      end
      start = 1'b1;
      lat = -1; done_at = -1; ndone = 0; busy_seen = 0; d16 = 0; d12 = 0;
      st = 0; stalled = 1'b0;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            rand_feat();
         end
         if (busy_a) busy_seen = 1;
         if (valid_a && lat < 0) begin
            lat = k;
            d16 = data_a;
            d12 = data_b;
         end
         if (done_a) begin
            ndone++;
            if (done_at < 0) done_at = k;
         end
         if (done_b) check("done_op12", k, done_at);
         if (stall > 0 && valid_a && !stalled) begin
            stalled = 1'b1;
            ready   = 1'b0;
         end else if (stall > 0 && stalled && !ready) begin
            st++;
            start = (st == 3);
            if (st == stall) ready = 1'b1;
         end else if (stall < 0) begin
            ready = ($urandom_range(0, 3) != 0);
         end
         if (done_at > 0 && k == done_at + 1) check("busy_after_done", busy_a, 0);
         if (done_at > 0 && k >= done_at + 3) break;
      end
      if (done_at < 0) check("run_timeout", 0, 1);
      start = 1'b0;
      ready = 1'b1;
   endtask

   initial begin
      int     lat, dat, nd, bs, hs0, rc;
      longint d16, d12;
      n_vec = 0; n_bad = 0; n_hs = 0; mode = 0;
      for (int s = 0; s < WSL; s++)
         for (int a = 0; a < DEP; a++) wm[s][a] = $urandom;
      rst = 1'b0; start = 1'b0; ready = 1'b1; feat = '0; base = '0; cnt = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      // Full-scale inputs, unit slice results; 12-bit instance saturates.
      mode = 0;
      for (int i = 0; i < IS; i++) feat[i*IP +: IP] = 8'hFF;
      check("model_pin_4335", model(feat, 5, 16), 4335);
      check("model_pin_4095", model(feat, 5, 12), 4095);
      hs0 = n_hs;
      run(5, 1, 0, lat, dat, nd, bs, d16, d12);
      check("t1_latency", lat, 10);
      check("t1_data", d16, 4335);
      check("t1_data_op12", d12, 4095);
      check("t1_done_count", nd, 1);
      check("t1_handshakes", n_hs - hs0, 1);

      // Only bit 0 active, slice weights 3 and 2.
      mode = 1;
      feat = '0;
      for (int i = 0; i < IS; i++) feat[i*IP] = 1'b1;
      check("model_pin_35", model(feat, 0, 16), 35);
      run(0, 1, 0, lat, dat, nd, bs, d16, d12);
      check("t2_data", d16, 35);
      check("t2_data_op12", d12, 35);

      // Address wrap 30,31,0,1.
      mode = 2;
      rand_feat();
      hs0 = n_hs;
      run(30, 4, 0, lat, dat, nd, bs, d16, d12);
      check("t4_handshakes", n_hs - hs0, 4);
      check("t4_done_count", nd, 1);

      // Downstream stall with a start pulse that must be ignored.
      rand_feat();
      hs0 = n_hs;
      run(int'($urandom_range(0, DEP - 1)), 2, 7, lat, dat, nd, bs, d16, d12);
      check("t5_latency", lat, 10);
      check("t5_handshakes", n_hs - hs0, 2);
      check("t5_done_count", nd, 1);

      // Empty run.
      hs0 = n_hs;
      run(7, 0, 0, lat, dat, nd, bs, d16, d12);
      check("t6_done_cycle", dat, 1);
      check("t6_done_count", nd, 1);
      check("t6_busy_seen", bs, 0);
      check("t6_handshakes", n_hs - hs0, 0);

      // Reset during the fourth FEED cycle aborts the run.
      rand_feat();
      base = 5'd3; cnt = 6'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_in_feed", xen_a, 1);
      rst = 1'b0;
      @(negedge clk);
      check_zero("abort");
      rst = 1'b1;
      nd = 0;
      repeat (20) begin
         @(negedge clk);
         if (done_a || valid_a) nd++;
      end
      check("abort_quiet", nd, 0);
      rand_feat();
      hs0 = n_hs;
      run(12, 1, 0, lat, dat, nd, bs, d16, d12);
      check("post_abort_latency", lat, 10);
      check("post_abort_done", nd, 1);
      check("post_abort_handshakes", n_hs - hs0, 1);

      // Random runs with random backpressure.
      for (int r = 0; r < 6; r++) begin
         rand_feat();
         rc  = int'($urandom_range(1, 5));
         hs0 = n_hs;
         run(int'($urandom_range(0, DEP - 1)), rc, -1, lat, dat, nd, bs, d16, d12);
         check("rand_handshakes", n_hs - hs0, rc);
         check("rand_done_count", nd, 1);
      end

      repeat (5) @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
